fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned reads to instruction memory,
// buffers up to two returned words in a small {pc,inst} FIFO for decode,
// and flushes everything on a redirect from execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [1:0]  count;

  // Two-entry FIFO kept as an explicit head and tail slot.
  logic [31:0] head_pc;
  logic [31:0] head_inst;
  logic [31:0] tail_pc;
  logic [31:0] tail_inst;

  logic        push;
  logic        pop;
  logic [1:0]  count_next;

  // mem_req must drop in the very cycle a redirect arrives, so it is decoded
  // from the state rather than registered. FETCH always has count < 2, so a
  // push can never hit a full FIFO.
  assign mem_req    = (state == FETCH) && !redirect;
  assign mem_addr   = fetch_pc;
  assign push       = mem_req && mem_ack;
  assign pop        = (count != 2'd0) && inst_ready && !redirect;
  assign count_next = count + {1'b0, push} - {1'b0, pop};

  assign inst_valid = (count != 2'd0);
  assign inst       = head_inst;
  assign inst_pc    = head_pc;

  // Control state: FSM, fetch address and occupancy; redirect wins over all.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
    end else if (redirect) begin
      state    <= FETCH;
      count    <= 2'd0;
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else begin
      count <= count_next;
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      case (state)
        BOOT:    state <= FETCH;
        FETCH:   if (count_next == 2'd2) state <= FULL;
        FULL:    if (pop) state <= FETCH;
        default: state <= BOOT;
      endcase
    end
  end

  // FIFO storage: a new word lands at the head when the head is free or is
  // leaving this cycle, otherwise behind it; a pop from two moves tail up.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the storage is reset because inst/inst_pc expose the head slot
    // directly and must read zero during reset; a plain buffer would not need it.
    if (reset) begin
      head_pc   <= 32'd0;
      head_inst <= 32'd0;
      tail_pc   <= 32'd0;
      tail_inst <= 32'd0;
    end else if (!redirect) begin
      if (pop && (count == 2'd2)) begin
        head_pc   <= tail_pc;
        head_inst <= tail_inst;
      end else if (push && ((count == 2'd0) || pop)) begin
        head_pc   <= fetch_pc;
        head_inst <= mem_rdata;
      end else if (push) begin
        tail_pc   <= fetch_pc;
        tail_inst <= mem_rdata;
      end
    end
  end

endmodule
